// File: rtl/neuron_cmd_sequencer.sv
// neuron_cmd_sequencer: decodes 1-2 byte host commands and sequences the
// neuron core through register writes, register reads and timesteps. It
// returns response bytes through the frontend output handshake.
module neuron_cmd_sequencer #(
  parameter int unsigned ADDR_W       = 6,
  parameter int unsigned STEP_TIMEOUT = 255,
  parameter int unsigned TMO_W        = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              in_fire,
  input  logic [7:0]        in_byte,
  input  logic              out_fire,
  output logic              have_out,
  output logic [7:0]        out_byte,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              step_req,
  input  logic              step_done,
  input  logic [7:0]        core_status,
  output logic              err_overrun,
  output logic              err_timeout
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WR_DATA   = 3'd1;
  localparam logic [2:0] S_RD_WAIT   = 3'd2;
  localparam logic [2:0] S_RD_DATA   = 3'd3;
  localparam logic [2:0] S_STEP_WAIT = 3'd4;
  localparam logic [2:0] S_OUT_HOLD  = 3'd5;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_STEP  = 2'b10;
  localparam logic [1:0] OP_READ  = 2'b11;

  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(STEP_TIMEOUT);
  localparam logic [7:0]       TMO_BYTE  = 8'hFF;

  logic [2:0]        state_q, state_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d, tmo_inc;

  logic              have_out_d;
  logic [7:0]        out_byte_d;
  logic              wr_en_d;
  logic [ADDR_W-1:0] wr_addr_d;
  logic [7:0]        wr_data_d;
  logic              rd_en_d;
  logic [ADDR_W-1:0] rd_addr_d;
  logic              step_req_d;
  logic              err_overrun_d;
  logic              err_timeout_d;
  logic              busy;

  // Next-state and next-output decode
  always_comb begin
    state_d       = state_q;
    tmo_d         = tmo_q;
    tmo_inc       = tmo_q + TMO_W'(1);
    have_out_d    = have_out;
    out_byte_d    = out_byte;
    wr_en_d       = 1'b0;
    wr_addr_d     = wr_addr;
    wr_data_d     = wr_data;
    rd_en_d       = 1'b0;
    rd_addr_d     = rd_addr;
    step_req_d    = step_req;
    err_overrun_d = err_overrun;
    err_timeout_d = err_timeout;
    busy          = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (in_fire) begin
          case (in_byte[7:6])
            OP_NOP: state_d = S_IDLE;
            OP_WRITE: begin
              wr_addr_d = in_byte[ADDR_W-1:0];
              state_d   = S_WR_DATA;
            end
            OP_STEP: begin
              step_req_d = 1'b1;
              tmo_d      = TMO_W'(0);
              state_d    = S_STEP_WAIT;
            end
            OP_READ: begin
              rd_addr_d = in_byte[ADDR_W-1:0];
              rd_en_d   = 1'b1;
              state_d   = S_RD_WAIT;
            end
            default: state_d = S_IDLE;
          endcase
        end
      end

      S_WR_DATA: begin
        if (in_fire) begin
          wr_data_d = in_byte;
          wr_en_d   = 1'b1;
          state_d   = S_IDLE;
        end
      end

      // A read strobe lost to ena=0 is reissued before advancing
      S_RD_WAIT: begin
        busy = 1'b1;
        if (rd_en) begin
          state_d = S_RD_DATA;
        end else begin
          rd_en_d = 1'b1;
        end
      end

      S_RD_DATA: begin
        busy       = 1'b1;
        out_byte_d = rd_data;
        have_out_d = 1'b1;
        state_d    = S_OUT_HOLD;
      end

      // step_done has priority over a timeout landing on the same cycle
      S_STEP_WAIT: begin
        busy  = 1'b1;
        tmo_d = tmo_inc;
        if (step_done) begin
          step_req_d = 1'b0;
          out_byte_d = core_status;
          have_out_d = 1'b1;
          state_d    = S_OUT_HOLD;
        end else if (tmo_inc == TMO_LIMIT) begin
          step_req_d    = 1'b0;
          err_timeout_d = 1'b1;
          out_byte_d    = TMO_BYTE;
          have_out_d    = 1'b1;
          state_d       = S_OUT_HOLD;
        end
      end

      S_OUT_HOLD: begin
        busy = 1'b1;
        if (out_fire && have_out) begin
          have_out_d = 1'b0;
          state_d    = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (busy && in_fire) begin
      err_overrun_d = 1'b1;
    end
  end

  // State, counter and output registers; frozen (strobes cleared) when ena=0
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      tmo_q       <= TMO_W'(0);
      have_out    <= 1'b0;
      out_byte    <= 8'h00;
      wr_en       <= 1'b0;
      wr_addr     <= ADDR_W'(0);
      wr_data     <= 8'h00;
      rd_en       <= 1'b0;
      rd_addr     <= ADDR_W'(0);
      step_req    <= 1'b0;
      err_overrun <= 1'b0;
      err_timeout <= 1'b0;
    end else if (ena) begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      have_out    <= have_out_d;
      out_byte    <= out_byte_d;
      wr_en       <= wr_en_d;
      wr_addr     <= wr_addr_d;
      wr_data     <= wr_data_d;
      rd_en       <= rd_en_d;
      rd_addr     <= rd_addr_d;
      step_req    <= step_req_d;
      err_overrun <= err_overrun_d;
      err_timeout <= err_timeout_d;
    end else begin
      wr_en <= 1'b0;
      rd_en <= 1'b0;
    end
  end

endmodule

// File: tb/tb_neuron_cmd_sequencer.sv
// Scoreboard bench for neuron_cmd_sequencer: stimulus pushes expected
// writes, reads and response bytes; a monitor pops and compares them.
module tb_neuron_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       in_fire;
  logic [7:0] in_byte;
  logic       out_fire;
  logic       have_out;
  logic [7:0] out_byte;
  logic       wr_en;
  logic [5:0] wr_addr;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [5:0] rd_addr;
  logic [7:0] rd_data;
  logic       step_req;
  logic       step_done;
  logic [7:0] core_status;
  logic       err_overrun;
  logic       err_timeout;

  int n_vec  = 0;
  int n_miss = 0;

  logic [5:0] exp_wr_addr_q[$];
  logic [7:0] exp_wr_data_q[$];
  logic [5:0] exp_rd_addr_q[$];
  logic [7:0] exp_out_q[$];

  logic [7:0] mem [64];

  neuron_cmd_sequencer #(
    .ADDR_W(6), .STEP_TIMEOUT(255), .TMO_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .in_fire(in_fire), .in_byte(in_byte), .out_fire(out_fire),
    .have_out(have_out), .out_byte(out_byte),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .step_req(step_req), .step_done(step_done), .core_status(core_status),
    .err_overrun(err_overrun), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // Core register file model: read data valid the cycle after rd_en
  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every strobe/response the DUT presents
  logic wr_en_prev = 1'b0;
  logic have_out_prev = 1'b0;
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      check("wr_en_width", 32'(wr_en_prev), 32'd0);
      check("wr_expected", 32'(exp_wr_addr_q.size() != 0), 32'd1);
      if (exp_wr_addr_q.size() != 0) begin
        check("wr_addr", 32'(wr_addr), 32'(exp_wr_addr_q.pop_front()));
        check("wr_data", 32'(wr_data), 32'(exp_wr_data_q.pop_front()));
      end
    end
    if (rd_en === 1'b1) begin
      check("rd_expected", 32'(exp_rd_addr_q.size() != 0), 32'd1);
      if (exp_rd_addr_q.size() != 0)
        check("rd_addr", 32'(rd_addr), 32'(exp_rd_addr_q.pop_front()));
    end
    if (have_out === 1'b1 && have_out_prev !== 1'b1) begin
      check("out_expected", 32'(exp_out_q.size() != 0), 32'd1);
      if (exp_out_q.size() != 0)
        check("out_byte", 32'(out_byte), 32'(exp_out_q.pop_front()));
    end
    wr_en_prev    = (wr_en === 1'b1);
    have_out_prev = (have_out === 1'b1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    in_byte = b;
    in_fire = 1'b1;
    tick();
    in_fire = 1'b0;
  endtask

  task automatic consume();
    int guard = 0;
    while (have_out !== 1'b1 && guard < 50) begin
      tick();
      guard++;
    end
    check("have_out_wait", 32'(have_out), 32'd1);
    out_fire = 1'b1;
    tick();
    out_fire = 1'b0;
    check("have_out_clear", 32'(have_out), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi;
    for (int i = 0; i < 64; i++) mem[i] = 8'(i);
    mem[9] = 8'h3C;
    rst_n = 1'b0; ena = 1'b1; in_fire = 1'b0; in_byte = 8'h00;
    out_fire = 1'b0; step_done = 1'b0; core_status = 8'h00;

    // Reset state
    tick(); tick();
    check("rst_have_out", 32'(have_out), 32'd0);
    check("rst_out_byte", 32'(out_byte), 32'd0);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_rd_en", 32'(rd_en), 32'd0);
    check("rst_rd_addr", 32'(rd_addr), 32'd0);
    check("rst_step_req", 32'(step_req), 32'd0);
    check("rst_err_overrun", 32'(err_overrun), 32'd0);
    check("rst_err_timeout", 32'(err_timeout), 32'd0);
    rst_n = 1'b1;
    tick();

    // WRITE 0x45, 0xA5
    exp_wr_addr_q.push_back(6'h05);
    exp_wr_data_q.push_back(8'hA5);
    send_byte(8'h45);
    send_byte(8'hA5);
    check("wr_pulse_now", 32'(wr_en), 32'd1);
    tick();
    check("wr_pulse_gone", 32'(wr_en), 32'd0);
    check("wr_no_resp", 32'(have_out), 32'd0);

    // READ 0xC9, core returns 0x3C, two-cycle latency
    exp_rd_addr_q.push_back(6'h09);
    exp_out_q.push_back(8'h3C);
    send_byte(8'hC9);
    check("rd_pulse", 32'(rd_en), 32'd1);
    tick();
    check("rd_lat1_no_out", 32'(have_out), 32'd0);
    tick();
    check("rd_lat2_out", 32'(have_out), 32'd1);
    consume();

    // STEP normal: step_done on the 10th cycle, status 0x81
    exp_out_q.push_back(8'h81);
    send_byte(8'h80);
    hi = 0;
    for (int i = 0; i < 9; i++) begin
      if (step_req) hi++;
      tick();
    end
    if (step_req) hi++;
    core_status = 8'h81;
    step_done = 1'b1;
    tick();
    step_done = 1'b0;
    check("step_req_cycles", 32'(hi), 32'd10);
    check("step_req_drop", 32'(step_req), 32'd0);
    check("step_err_timeout", 32'(err_timeout), 32'd0);
    consume();

    // Overrun: 0x12 arrives during STEP_WAIT
    exp_out_q.push_back(8'h77);
    send_byte(8'h80);
    send_byte(8'h12);
    check("overrun_set", 32'(err_overrun), 32'd1);
    check("overrun_step_alive", 32'(step_req), 32'd1);
    core_status = 8'h77;
    step_done = 1'b1;
    tick();
    step_done = 1'b0;
    consume();

    // STEP timeout: no step_done for 255 cycles
    exp_out_q.push_back(8'hFF);
    send_byte(8'h80);
    hi = 0;
    while (step_req === 1'b1 && hi < 400) begin
      hi++;
      tick();
    end
    check("tmo_cycles", 32'(hi), 32'd255);
    check("tmo_err", 32'(err_timeout), 32'd1);
    check("tmo_have_out", 32'(have_out), 32'd1);
    consume();

    // READ with ena=0: ignored, outputs frozen
    ena = 1'b0;
    send_byte(8'hC9);
    tick(); tick();
    check("ena0_rd_en", 32'(rd_en), 32'd0);
    check("ena0_have_out", 32'(have_out), 32'd0);
    check("ena0_out_byte", 32'(out_byte), 32'hFF);
    check("ena0_err_timeout", 32'(err_timeout), 32'd1);
    ena = 1'b1;
    tick(); tick(); tick();
    check("ena1_no_out", 32'(have_out), 32'd0);

    // Reset while in WR_DATA: no write may follow
    send_byte(8'h45);
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    check("rst_mid_err_timeout", 32'(err_timeout), 32'd0);
    check("rst_mid_err_overrun", 32'(err_overrun), 32'd0);
    tick(); tick(); tick();
    check("rst_mid_wr_en", 32'(wr_en), 32'd0);

    // step_done on the timeout cycle wins
    exp_out_q.push_back(8'h5A);
    send_byte(8'h80);
    for (int i = 0; i < 254; i++) tick();
    check("edge_step_req", 32'(step_req), 32'd1);
    core_status = 8'h5A;
    step_done = 1'b1;
    tick();
    step_done = 1'b0;
    check("edge_no_tmo", 32'(err_timeout), 32'd0);
    consume();

    // out_fire with nothing pending is ignored
    out_fire = 1'b1;
    tick();
    out_fire = 1'b0;
    tick();
    check("idle_out_fire", 32'(have_out), 32'd0);

    check("wr_q_drained", 32'(exp_wr_addr_q.size()), 32'd0);
    check("rd_q_drained", 32'(exp_rd_addr_q.size()), 32'd0);
    check("out_q_drained", 32'(exp_out_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/neuron_cmd_sequencer.md
Name: neuron_cmd_sequencer

Overview:
- Command-level controller behind the neuron I/O handshake frontend.
- Consumes bytes accepted by the frontend (one per `in_fire`) and decodes 1–2 byte commands.
- Sequences the neuron core: register writes, register reads and timestep execution.
- Presents response bytes back through the frontend output handshake (`have_out`/`out_fire`).

Parameters:
- ADDR_W, 6, core register address width; must be ≤ 6 so the address fits in command byte bits [5:0].
- STEP_TIMEOUT, 255, maximum cycles to wait for `step_done` before aborting a STEP.
- TMO_W, 8, width of the timeout counter; must satisfy 2^TMO_W > STEP_TIMEOUT.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- ena  in  1  design enable; FSM frozen when low.
- in_fire  in  1  one-cycle strobe: `in_byte` accepted by the frontend.
- in_byte  in  8  synchronized input byte (`ui_in_sync`).
- out_fire  in  1  one-cycle strobe: host consumed `out_byte`.
- have_out  out  1  response byte valid; drives frontend `have_out`.
- out_byte  out  8  response byte.
- wr_en  out  1  one-cycle core register write strobe.
- wr_addr  out  ADDR_W  core write address.
- wr_data  out  8  core write data.
- rd_en  out  1  one-cycle core register read strobe.
- rd_addr  out  ADDR_W  core read address.
- rd_data  in  8  core read data, valid exactly 1 cycle after `rd_en`.
- step_req  out  1  level request to run one neuron timestep.
- step_done  in  1  one-cycle pulse from core, timestep complete.
- core_status  in  8  core status/spike byte, sampled at `step_done`.
- err_overrun  out  1  sticky: a byte arrived while the FSM was busy.
- err_timeout  out  1  sticky: a STEP timed out.

Behaviour:
- Reset (`rst_n` = 0 at a clk edge):
  - State goes to IDLE.
  - All outputs go to 0: `have_out`, `out_byte`, `wr_en`, `wr_addr`, `wr_data`, `rd_en`, `rd_addr`, `step_req`, `err_overrun`, `err_timeout`.
  - The timeout counter clears.
  - Reset mid-command abandons the command; no pending `wr_en`/`rd_en` is issued.
- `ena` = 0:
  - State, counters and output registers hold.
  - `wr_en` and `rd_en` are forced 0.
  - `in_fire`, `out_fire` and `step_done` are ignored.
- Opcode is `in_byte[7:6]`; the address field is `in_byte[ADDR_W-1:0]`.
  - 00 NOP: ignored; stay in IDLE.
  - 01 WRITE: latch `wr_addr`; go to WR_DATA.
  - 10 STEP: assert `step_req`; clear the timeout counter; go to STEP_WAIT.
  - 11 READ: latch `rd_addr`; pulse `rd_en` on the next cycle; go to RD_WAIT.
- States and transitions:
  - IDLE: decode on `in_fire`.
  - WR_DATA: on `in_fire`, `wr_data` ← `in_byte`, `wr_en` = 1 for exactly one cycle (the cycle after `in_fire`), then IDLE. No response byte.
  - RD_WAIT: `rd_en` high for its single cycle. On the following cycle, `out_byte` ← `rd_data`, `have_out` ← 1, go to OUT_HOLD. Read latency is 2 cycles from `in_fire` to `have_out`.
  - STEP_WAIT: `step_req` held high; the counter increments each enabled cycle.
    - On `step_done`: `step_req` ← 0, `out_byte` ← `core_status`, `have_out` ← 1, go to OUT_HOLD.
    - If the counter reaches STEP_TIMEOUT without `step_done`: `step_req` ← 0, `err_timeout` ← 1, `out_byte` ← 8'hFF, `have_out` ← 1, go to OUT_HOLD.
    - `step_done` on the same cycle as timeout: `step_done` wins; no error.
  - OUT_HOLD: `have_out` and `out_byte` stable until `out_fire`. Then `have_out` ← 0 on the next edge and go to IDLE.
- Busy rule: `in_fire` during STEP_WAIT, RD_WAIT or OUT_HOLD drops the byte and sets `err_overrun` ← 1. The FSM is otherwise unaffected.
- `step_done` outside STEP_WAIT is ignored.
- `out_fire` while `have_out` = 0 is ignored.
- Error flags are sticky until reset.
- At most one command is in flight; no queueing.

Test Plan:
- Reset check: drive `rst_n` = 0 for 2 cycles → all outputs 0 and state IDLE.
- WRITE: `in_fire` 0x45 then 0xA5 → a single-cycle `wr_en` with `wr_addr` = 0x05, `wr_data` = 0xA5; `have_out` stays 0.
- READ, core returns 0x3C:
  - `in_fire` 0xC9 → `rd_en` pulse, `rd_addr` = 0x09.
  - `have_out` = 1 with `out_byte` = 0x3C two cycles after `in_fire`.
  - After `out_fire`, `have_out` = 0 on the next edge and the FSM is back in IDLE.
- STEP normal: `in_fire` 0x80, `step_done` after 10 cycles with `core_status` = 0x81 → `step_req` high for 10 cycles, then `out_byte` = 0x81, `have_out` = 1, `err_timeout` = 0.
- STEP timeout, STEP_TIMEOUT = 255, no `step_done` → after 255 cycles `step_req` = 0, `out_byte` = 0xFF, `err_timeout` = 1.
- Overrun and ena:
  - `in_fire` 0x12 during STEP_WAIT → `err_overrun` = 1, byte dropped, STEP still completes.
  - Repeat a READ with `ena` = 0 → no `rd_en`, outputs frozen.
  - Reset asserted in WR_DATA → no `wr_en` is ever issued.
